// File: rtl/counter_n_bit_mod.sv
// -----------------------------------------------------------------------------
// counter_n_bit_mod
//
// Loadable up/down counter with a run-time inclusive upper bound (Max_val).
// At a bound the counter either wraps (Wrap pulse) or holds (Sat level),
// selected per cycle by Saturate. Intended to drive timers, clock dividers
// and address sequencers directly.
//
// Parameters
//   WIDTH      counter/data width in bits (2..32)
//   RESET_VAL  value loaded by Reset; must not exceed any Max_val in use
//
// Ports
//   Clk        system clock, all state changes on the rising edge
//   Reset      synchronous active-high reset (highest priority)
//   Load       parallel load of Count_in, clamped to Max_val
//   Count_en   count enable
//   Up         1 = increment, 0 = decrement
//   Saturate   1 = hold at the bound, 0 = wrap around
//   Max_val    inclusive upper bound of the count range 0..Max_val
//   Count_in   load value
//   Count_out  registered count
//   Tc         combinational terminal count for the current direction
//   Wrap       registered pulse: the previous edge wrapped
//   Sat        registered level: the counter is pinned at a bound
// -----------------------------------------------------------------------------
module counter_n_bit_mod #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Count_en,
    input  logic             Up,
    input  logic             Saturate,
    input  logic [WIDTH-1:0] Max_val,
    input  logic [WIDTH-1:0] Count_in,
    output logic [WIDTH-1:0] Count_out,
    output logic             Tc,
    output logic             Wrap,
    output logic             Sat
);

    localparam logic [WIDTH-1:0] RESET_CNT = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO      = '0;

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             sat_reg;
    logic             sat_next;

    // Bound comparisons shared by the next-state logic and Tc.
    logic             below_max;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_val;

    assign below_max = (count_reg < Max_val);
    assign at_max    = (count_reg == Max_val);
    assign at_zero   = (count_reg == ZERO);

    // Loads never place the counter outside 0..Max_val.
    assign load_val  = (Count_in > Max_val) ? Max_val : Count_in;

    // -------------------------------------------------------------------------
    // Next-state logic. Wrap and Sat default to 0 so both clear on any edge
    // that does not itself wrap or saturate (including hold and load).
    // -------------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        sat_next   = 1'b0;

        if (Load) begin
            count_next = load_val;
        end else if (Count_en) begin
            if (Up) begin
                if (below_max) begin
                    count_next = count_reg + ONE;
                end else if (Saturate) begin
                    // Also covers an out-of-range count after Max_val was
                    // lowered: clamp down onto the bound and report it.
                    count_next = Max_val;
                    sat_next   = 1'b1;
                end else begin
                    // At or above the bound: the next value in range is 0.
                    // With Max_val = all ones this is plain modulo rollover.
                    count_next = ZERO;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    // Decrement even when above Max_val so an out-of-range
                    // count walks back into the range.
                    count_next = count_reg - ONE;
                end else if (Saturate) begin
                    count_next = ZERO;
                    sat_next   = 1'b1;
                end else begin
                    count_next = Max_val;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers with synchronous reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_reg <= RESET_CNT;
            wrap_reg  <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            sat_reg   <= sat_next;
        end
    end

    // Tc uses equality only, so an out-of-range count never flags terminal.
    assign Tc        = Count_en & ~Load & (Up ? at_max : at_zero);
    assign Count_out = count_reg;
    assign Wrap      = wrap_reg;
    assign Sat       = sat_reg;

endmodule

// File: tb/tb_counter_n_bit_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_n_bit_mod
//
// Directed bench for counter_n_bit_mod at WIDTH=4. A behavioural model using
// plain integer arithmetic predicts Count_out/Wrap/Sat/Tc; one compare process
// checks the DUT against it each cycle and against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_counter_n_bit_mod;

    localparam int W  = 4;
    localparam int RV = 0;

    logic         Clk;
    logic         Reset;
    logic         Load;
    logic         Count_en;
    logic         Up;
    logic         Saturate;
    logic [W-1:0] Max_val;
    logic [W-1:0] Count_in;
    logic [W-1:0] Count_out;
    logic         Tc;
    logic         Wrap;
    logic         Sat;

    counter_n_bit_mod #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .Count_en  (Count_en),
        .Up        (Up),
        .Saturate  (Saturate),
        .Max_val   (Max_val),
        .Count_in  (Count_in),
        .Count_out (Count_out),
        .Tc        (Tc),
        .Wrap      (Wrap),
        .Sat       (Sat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model state (integers) and literal expectations (-1 = not pinned).
    int m_cnt;
    int m_wrap;
    int m_sat;
    bit model_valid;
    int lit_cnt;
    int lit_wrap;
    int lit_sat;
    int lit_tc;

    int checks;
    int failures;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Single compare process, sampling mid-cycle on the falling edge.
    always @(negedge Clk) begin
        if (model_valid) begin
            int m_tc;
            m_tc = (Count_en && !Load &&
                    (Up ? (m_cnt == int'(Max_val)) : (m_cnt == 0))) ? 1 : 0;
            chk("model_count", int'(Count_out), m_cnt);
            chk("model_wrap",  int'(Wrap),      m_wrap);
            chk("model_sat",   int'(Sat),       m_sat);
            chk("model_tc",    int'(Tc),        m_tc);
            if (lit_cnt  >= 0) chk("lit_count", int'(Count_out), lit_cnt);
            if (lit_wrap >= 0) chk("lit_wrap",  int'(Wrap),      lit_wrap);
            if (lit_sat  >= 0) chk("lit_sat",   int'(Sat),       lit_sat);
            if (lit_tc   >= 0) chk("lit_tc",    int'(Tc),        lit_tc);
        end
    end

    // One clock edge: predict from the inputs held across the edge, then
    // publish the prediction and literals; inputs change only after negedge.
    task automatic tick(input int e_cnt, input int e_wrap, input int e_sat, input int e_tc);
        int n;
        int w;
        int s;
        int mx;
        mx = int'(Max_val);
        n  = m_cnt;
        w  = 0;
        s  = 0;
        if (Reset) begin
            n = RV;
        end else if (Load) begin
            n = (int'(Count_in) > mx) ? mx : int'(Count_in);
        end else if (Count_en) begin
            if (Up) begin
                if (m_cnt < mx)    n = m_cnt + 1;
                else if (Saturate) begin n = mx; s = 1; end
                else               begin n = 0;  w = 1; end
            end else begin
                if (m_cnt > 0)     n = m_cnt - 1;
                else if (Saturate) s = 1;
                else               begin n = mx; w = 1; end
            end
        end
        @(posedge Clk);
        #1;
        m_cnt       = n;
        m_wrap      = w;
        m_sat       = s;
        model_valid = 1'b1;
        lit_cnt     = e_cnt;
        lit_wrap    = e_wrap;
        lit_sat     = e_sat;
        lit_tc      = e_tc;
        @(negedge Clk);
        #1;
        $display("tick t=%0t cnt=%0d wrap=%0b sat=%0b tc=%0b", $time, Count_out, Wrap, Sat, Tc);
    endtask

    task automatic do_load(input int val);
        Load = 1'b1; Count_in = W'(val);
        tick(-1, 0, 0, 0);
        Load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; model_valid = 1'b0;
        m_cnt = 0; m_wrap = 0; m_sat = 0;
        lit_cnt = -1; lit_wrap = -1; lit_sat = -1; lit_tc = -1;
        Reset = 1'b1; Load = 1'b0; Count_en = 1'b0; Up = 1'b1; Saturate = 1'b0;
        Max_val = 4'd9; Count_in = 4'd0;

        // Reset state.
        tick(0, 0, 0, 0);
        Reset = 1'b0;

        // Count to 5, then reset with Load asserted: Load ignored.
        Count_en = 1'b1;
        for (int i = 1; i <= 5; i++) tick(i, 0, 0, -1);
        Reset = 1'b1; Load = 1'b1; Count_in = 4'd7;
        tick(0, 0, 0, 0);
        Reset = 1'b0; Load = 1'b0;

        // Decade wrap up: 1..9,0,1,2; Wrap only on the 0 after 9.
        for (int i = 1; i <= 12; i++) tick(i % 10, (i == 10) ? 1 : 0, 0, ((i % 10) == 9) ? 1 : 0);

        // Wrap down from 2: 1,0,9,8.
        Count_en = 1'b0;
        do_load(2);
        Count_en = 1'b1; Up = 1'b0;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(9, 1, 0, 0);
        tick(8, 0, 0, 0);

        // Saturate up at 12, then reverse.
        Max_val = 4'd12; Count_en = 1'b0;
        do_load(10);
        Count_en = 1'b1; Up = 1'b1; Saturate = 1'b1;
        tick(11, 0, 0, 0);
        tick(12, 0, 0, 1);
        tick(12, 0, 1, 1);
        tick(12, 0, 1, 1);
        tick(12, 0, 1, 1);
        Up = 1'b0;
        tick(11, 0, 0, 0);

        // Load clamp and priority over Count_en.
        Max_val = 4'd9; Saturate = 1'b0; Up = 1'b1;
        Load = 1'b1; Count_in = 4'd14;
        tick(9, 0, 0, 0);
        Count_in = 4'd3;
        tick(3, 0, 0, 0);
        Load = 1'b0; Count_en = 1'b0;
        tick(3, 0, 0, 0);

        // Full range rollover at Max_val = 15.
        Max_val = 4'd15;
        do_load(15);
        Count_en = 1'b1;
        tick(0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) tick(i, 0, 0, 0);

        // Shrink Max_val below the count: up in wrap mode goes to 0.
        Max_val = 4'd5;
        tick(0, 1, 0, 0);

        // Shrink with Saturate: clamps to the new bound.
        Max_val = 4'd15; Count_en = 1'b0;
        do_load(8);
        Max_val = 4'd5; Saturate = 1'b1; Count_en = 1'b1;
        tick(5, 0, -1, 1);

        // Out-of-range down counting decrements normally, Tc stays 0.
        Max_val = 4'd15; Count_en = 1'b0;
        do_load(8);
        Max_val = 4'd5; Up = 1'b0; Count_en = 1'b1;
        tick(7, 0, 0, 0);

        // Max_val = 0 in wrap mode: stays 0 with Wrap held high.
        Max_val = 4'd0; Saturate = 1'b0; Up = 1'b1; Count_en = 1'b0;
        do_load(3);
        Count_en = 1'b1;
        tick(0, 1, 0, 1);
        tick(0, 1, 0, 1);

        // Saturate at zero going down; Sat clears when disabled.
        Max_val = 4'd9; Count_en = 1'b0;
        do_load(0);
        Up = 1'b0; Saturate = 1'b1; Count_en = 1'b1;
        tick(0, 0, 1, 1);
        Count_en = 1'b0;
        tick(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
